// File: rtl/prog_moore_fsm.sv
// Table-driven Moore machine: transition and output tables loaded at run time.
// Adds a live-state-count legality check, sticky error and saturating step counter.
module prog_moore_fsm #(
  parameter int STATE_W = 3,
  parameter int IN_W    = 2,
  parameter int OUT_W   = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IN_W-1:0]    sw_in,
  input  logic               ctrl_in,
  input  logic [STATE_W-1:0] state_in,
  input  logic               load_in,
  input  logic               cfg_we,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [IN_W-1:0]    cfg_sym,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic               cfg_out_we,
  input  logic [OUT_W-1:0]   cfg_out,
  input  logic               cfg_nstates_we,
  input  logic [STATE_W:0]   cfg_nstates,
  output logic [STATE_W-1:0] state,
  output logic [OUT_W-1:0]   out,
  output logic               err,
  output logic [CNT_W-1:0]   steps
);

  localparam int NS = 1 << STATE_W;
  localparam int NI = 1 << IN_W;
  localparam logic [STATE_W:0] NS_V = (STATE_W+1)'(NS);

  logic [STATE_W-1:0] next_tbl_q [NS][NI];
  logic [STATE_W-1:0] next_tbl_d [NS][NI];
  logic [OUT_W-1:0]   out_tbl_q [NS];
  logic [OUT_W-1:0]   out_tbl_d [NS];
  logic [STATE_W:0]   nstates_q, nstates_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   steps_q, steps_d;

  logic [STATE_W-1:0] nxt;
  logic               legal;

  assign nxt   = next_tbl_q[state_q][sw_in];
  assign legal = {1'b0, nxt} < nstates_q;

  // Config writes; a step in the same cycle still reads the old tables.
  always_comb begin
    next_tbl_d = next_tbl_q;
    out_tbl_d  = out_tbl_q;
    nstates_d  = nstates_q;
    if (cfg_we)
      next_tbl_d[cfg_state][cfg_sym] = cfg_next;
    if (cfg_out_we)
      out_tbl_d[cfg_state] = cfg_out;
    if (cfg_nstates_we && (cfg_nstates != '0)
        && (cfg_nstates <= NS_V))
      nstates_d = cfg_nstates;
  end

  // Next state: load beats step; illegal target falls back to state_in.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    steps_d = steps_q;
    if (load_in) begin
      state_d = state_in;
      steps_d = '0;
    end else if (ctrl_in) begin
      if (legal) begin
        state_d = nxt;
        if (steps_q != '1)
          steps_d = steps_q + CNT_W'(1);
      end else begin
        state_d = state_in;
        err_d   = 1'b1;
      end
    end
  end

  // Moore output latched only when a state is entered.
  always_comb begin
    out_d = out_q;
    if (load_in || ctrl_in)
      out_d = out_tbl_q[state_d];
  end

  // State, tables and counters; reset restores self-loop tables.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < NS; s++) begin
        for (int i = 0; i < NI; i++)
          next_tbl_q[s][i] <= STATE_W'(s);
        out_tbl_q[s] <= '0;
      end
      nstates_q <= NS_V;
      state_q   <= state_in;
      out_q     <= '0;
      err_q     <= 1'b0;
      steps_q   <= '0;
    end else begin
      next_tbl_q <= next_tbl_d;
      out_tbl_q  <= out_tbl_d;
      nstates_q  <= nstates_d;
      state_q    <= state_d;
      out_q      <= out_d;
      err_q      <= err_d;
      steps_q    <= steps_d;
    end
  end

  assign state = state_q;
  assign out   = out_q;
  assign err   = err_q;
  assign steps = steps_q;

endmodule

// File: doc/prog_moore_fsm.md
# prog_moore_fsm

Table-driven, parametrised Moore state machine: the same state/output behaviour as the team's fixed-function Moore blocks, but the transition and output tables are loaded at run time through a configuration port. It sits between the switch/input conditioning logic and the LED/output drivers. Any machine with up to 2^STATE_W states and 2^IN_W input symbols runs without new RTL. It adds a live-state-count check, a sticky error flag and a saturating step counter.

## Interface
- STATE_W, 3: state encoding width; table holds 2^STATE_W states
- IN_W, 2: input symbol width; 2^IN_W transitions per state
- OUT_W, 1: Moore output width
- CNT_W, 16: step counter width
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- sw_in  in  IN_W  input symbol sampled on each step
- ctrl_in  in  1  step enable; one transition per cycle it is high
- state_in  in  STATE_W  initial state, loaded on reset and on load_in
- load_in  in  1  reload state from state_in without clearing tables
- cfg_we  in  1  write one transition entry
- cfg_state  in  STATE_W  entry row (current state)
- cfg_sym  in  IN_W  entry column (input symbol)
- cfg_next  in  STATE_W  next state for (cfg_state, cfg_sym)
- cfg_out_we  in  1  write output entry for cfg_state
- cfg_out  in  OUT_W  Moore output of cfg_state
- cfg_nstates_we  in  1  write live state count
- cfg_nstates  in  STATE_W+1  number of legal states, 1..2^STATE_W
- state  out  STATE_W  current state
- out  out  OUT_W  registered Moore output of current state
- err  out  1  sticky: an illegal state was reached
- steps  out  CNT_W  saturating count of accepted steps

## Operation
- Storage: next_tbl[2^STATE_W][2^IN_W] of STATE_W bits; out_tbl[2^STATE_W] of OUT_W bits; nstates register.
- Reset (reset_n low at clk edge): next_tbl[s][i] = s (self-loop) for all entries; out_tbl = 0; nstates = 2^STATE_W; state = state_in; out = 0; err = 0; steps = 0. All config writes and steps are ignored while reset_n is low.
- Step (ctrl_in high, load_in low): nxt = next_tbl[state][sw_in].
  - If nxt < nstates: state <= nxt; out <= out_tbl[nxt]; steps += 1, saturating at all-ones.
  - If nxt >= nstates: state <= state_in; out <= out_tbl[state_in]; err <= 1; steps unchanged.
- Load (load_in high): state <= state_in; out <= out_tbl[state_in]; steps <= 0; err unchanged. load_in has priority over ctrl_in in the same cycle.
- Config writes are independent of one another and may occur together. A write to an entry read by a step in the same cycle takes effect only for later steps; the step uses the pre-write value. The same applies to out_tbl and nstates.
- cfg_nstates values of 0 or above 2^STATE_W are ignored. Shrinking nstates below the current state does not move state; the next step checks legality of its target only.
- err clears only on reset.

## Timing
- All outputs are registered. state, out and steps update on the clk edge that samples ctrl_in or load_in high, so latency is 1 cycle.
- out always equals out_tbl[state] as of the cycle state was entered. A later cfg_out write to the current state appears on out only after the next step or load into that state.
- ctrl_in held high gives one transition per cycle. There is no handshake and no back-pressure.
- Reset mid-run discards tables; software must reload the configuration after every reset.

## Test plan
- Reset with state_in=0, then step with sw_in=3 -> state stays 0 (self-loop), out=0, steps=1, err=0.
- Load a 3-state machine: nstates=3; state 0 -> 1 on any input, out 0. State 1: sw 0->1, 1->0, 2/3->2, out 0. State 2: sw 0/2->2, 1/3->0, out 1. Reload to 0, then step sw_in sequence 0,0,2,0,1 -> states 1,1,2,2,0; out 0,0,1,1,0; steps=5.
- With the machine in state 1, set next_tbl[1][3]=5 and step with sw_in=3 -> state=state_in (0), out=0, err=1, steps unchanged. err stays 1 through a following load.
- In the same cycle, cfg_we rewrites next_tbl[1][0]=2 while a step runs with state=1, sw_in=0 -> state becomes 1. A second step with sw_in=0 -> state becomes 2.
- Assert ctrl_in and load_in together with state_in=2 -> state=2, out=out_tbl[2], steps=0.
- With CNT_W=4, run 20 legal steps -> steps saturates at 15. Pull reset_n low mid-run -> all outputs return to reset values on that edge.
